// File: rtl/alu_seq_unit.sv
// ============================================================================
// Module      : alu_seq_unit
// Description : Decodes alu_op/funct into a 4-bit ALU control, computes a
//               registered result, and shifts iteratively at 1 bit per cycle.
//               Valid/ready handshakes on both the issue and writeback sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_unit #(
    parameter int WIDTH   = 8,
    parameter int FUNCT_W = 4,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         ctrl,
    output logic               zero,
    output logic               busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [3:0] c_ctrl_add    = 4'b0000;
    localparam logic [3:0] c_ctrl_sub    = 4'b0001;
    localparam logic [3:0] c_ctrl_and    = 4'b0010;
    localparam logic [3:0] c_ctrl_or     = 4'b0011;
    localparam logic [3:0] c_ctrl_pass   = 4'b0100;
    localparam logic [3:0] c_ctrl_redand = 4'b0101;
    localparam logic [3:0] c_ctrl_redor  = 4'b0110;
    localparam logic [3:0] c_ctrl_shl    = 4'b0111;
    localparam logic [3:0] c_ctrl_xor    = 4'b1000;
    localparam logic [3:0] c_ctrl_shr    = 4'b1001;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_ctrl;
    logic               r_zero;
    logic               r_out_valid;
    logic [SHAMT_W-1:0] r_cnt;

    logic [3:0]         w_ctrl;
    logic [WIDTH-1:0]   w_alu_res;
    logic [WIDTH-1:0]   w_shift_next;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_shift;
    logic               w_accept;

    assign in_ready  = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_shamt   = b[SHAMT_W-1:0];
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ctrl      = r_ctrl;
    assign zero      = r_zero;
    assign busy      = (r_state != c_st_idle);

    // Unlisted alu_op/funct pairs fall through to pass-b.
    always_comb begin
        w_ctrl = c_ctrl_pass;
        case (alu_op)
            2'b00: begin
                case (funct)
                    FUNCT_W'(0): w_ctrl = c_ctrl_add;
                    FUNCT_W'(1): w_ctrl = c_ctrl_sub;
                    FUNCT_W'(2): w_ctrl = c_ctrl_and;
                    FUNCT_W'(3): w_ctrl = c_ctrl_or;
                    FUNCT_W'(4): w_ctrl = c_ctrl_xor;
                    FUNCT_W'(5): w_ctrl = c_ctrl_redand;
                    FUNCT_W'(6): w_ctrl = c_ctrl_redor;
                    FUNCT_W'(7): w_ctrl = c_ctrl_shr;
                    default:     w_ctrl = c_ctrl_pass;
                endcase
            end
            2'b01: begin
                case (funct)
                    FUNCT_W'(0): w_ctrl = c_ctrl_add;
                    FUNCT_W'(1): w_ctrl = c_ctrl_sub;
                    FUNCT_W'(6): w_ctrl = c_ctrl_shr;
                    FUNCT_W'(7): w_ctrl = c_ctrl_shl;
                    default:     w_ctrl = c_ctrl_pass;
                endcase
            end
            2'b10:   w_ctrl = funct[FUNCT_W-1] ? c_ctrl_pass : c_ctrl_sub;
            default: w_ctrl = c_ctrl_pass;
        endcase
    end

    assign w_is_shift = (w_ctrl == c_ctrl_shl) || (w_ctrl == c_ctrl_shr);

    // Shift codes yield a here; that is the shamt=0 result.
    always_comb begin
        w_alu_res = b;
        case (w_ctrl)
            c_ctrl_add:    w_alu_res = a + b;
            c_ctrl_sub:    w_alu_res = a - b;
            c_ctrl_and:    w_alu_res = a & b;
            c_ctrl_or:     w_alu_res = a | b;
            c_ctrl_xor:    w_alu_res = a ^ b;
            c_ctrl_redand: w_alu_res = {{(WIDTH-1){1'b0}}, &a};
            c_ctrl_redor:  w_alu_res = {{(WIDTH-1){1'b0}}, |a};
            c_ctrl_shl:    w_alu_res = a;
            c_ctrl_shr:    w_alu_res = a;
            default:       w_alu_res = b;
        endcase
    end

    assign w_shift_next = (r_ctrl == c_ctrl_shl) ? (r_result << 1) : (r_result >> 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_result    <= '0;
            r_ctrl      <= c_ctrl_pass;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_st_shift: begin
                    r_result <= w_shift_next;
                    r_cnt    <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                        r_zero      <= (w_shift_next == '0);
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_ctrl <= w_ctrl;
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_result    <= a;
                            r_cnt       <= w_shamt;
                            r_zero      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_state     <= c_st_shift;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= c_st_done;
                        end
                    end else if ((r_state == c_st_done) && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
// ============================================================================
// Module      : tb_alu_seq_unit
// Description : Scoreboard bench for alu_seq_unit with an independent model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [3:0] funct;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] ctrl;
    logic       zero;
    logic       busy;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] ctl;
        logic       z;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(8), .FUNCT_W(4), .SHAMT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ctrl(ctrl), .zero(zero), .busy(busy)
    );

    function automatic logic [3:0] model_ctrl(input logic [1:0] op, input logic [3:0] f);
        logic [3:0] c;
        c = 4'b0100;
        if (op == 2'b00) begin
            case (f)
                4'd0: c = 4'b0000;  4'd1: c = 4'b0001;
                4'd2: c = 4'b0010;  4'd3: c = 4'b0011;
                4'd4: c = 4'b1000;  4'd5: c = 4'b0101;
                4'd6: c = 4'b0110;  4'd7: c = 4'b1001;
                default: c = 4'b0100;
            endcase
        end else if (op == 2'b01) begin
            if (f == 4'd0) c = 4'b0000;
            else if (f == 4'd1) c = 4'b0001;
            else if (f == 4'd6) c = 4'b1001;
            else if (f == 4'd7) c = 4'b0111;
        end else if (op == 2'b10) begin
            c = f[3] ? 4'b0100 : 4'b0001;
        end
        return c;
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [3:0] f,
                                   input logic [7:0] x, input logic [7:0] y);
        exp_t       r;
        logic [7:0] v;
        r.ctl = model_ctrl(op, f);
        case (r.ctl)
            4'b0000: v = x + y;
            4'b0001: v = x - y;
            4'b0010: v = x & y;
            4'b0011: v = x | y;
            4'b1000: v = x ^ y;
            4'b0101: v = (x == 8'hFF) ? 8'd1 : 8'd0;
            4'b0110: v = (x != 8'h00) ? 8'd1 : 8'd0;
            4'b0111: v = x << y[2:0];
            4'b1001: v = x >> y[2:0];
            default: v = y;
        endcase
        r.res = v;
        r.z   = (v == 8'h00);
        return r;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [3:0] f,
                         input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = f;
        a        = x;
        b        = y;
        sb.push_back(model(op, f, x, y));
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b00;
        funct     = 4'd0;
        a         = 8'h11;
        b         = 8'h22;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({out_valid, result, ctrl, zero, busy, in_ready} !== {1'b0, 8'h00, 4'b0100, 1'b0, 1'b0, 1'b1}) begin
                tests_failed++;
                $display("FAIL reset_state: got ov=%b res=%h ctrl=%b z=%b busy=%b rdy=%b, want ov=0 res=00 ctrl=0100 z=0 busy=0 rdy=1",
                         out_valid, result, ctrl, zero, busy, in_ready);
            end
        end
        reset_n = 1'b1;
        sb.push_back(model(2'b00, 4'd0, 8'h11, 8'h22));
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        e = sb.pop_front();
        if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z}) begin
            tests_failed++;
            $display("FAIL first_accept: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                     out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got ov=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(2'b00, 4'd0, 8'hF0, 8'h20);
        @(negedge clk);
        tests_run++;
        e = sb.pop_front();
        if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z} || result !== 8'h10) begin
            tests_failed++;
            $display("FAIL b2b_add: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                     out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
        end
        drive(2'b10, 4'd0, 8'h33, 8'h33);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: got in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        e = sb.pop_front();
        if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z} || zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_cmp: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                     out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_shift();
        logic [1:0] ops [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        logic [3:0] fs  [4] = '{4'd7, 4'd7, 4'd7, 4'd7};
        logic [7:0] as  [4] = '{8'h81, 8'h81, 8'hF0, 8'h01};
        logic [7:0] bs  [4] = '{8'h03, 8'hF8, 8'h0C, 8'h02};
        int         lat [4] = '{4, 1, 5, 3};
        int         cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], fs[i], as[i], bs[i]);
            @(negedge clk);
            in_valid = 1'b0;
            a = 8'hFF;
            b = 8'h00;
            cyc = 1;
            while (!out_valid && cyc < 20) begin
                tests_run++;
                if (in_ready !== 1'b0 || busy !== 1'b1 || ctrl !== model_ctrl(ops[i], fs[i])) begin
                    tests_failed++;
                    $display("FAIL shift_stall[%0d]: got rdy=%b busy=%b ctrl=%b, want 0 1 %b",
                             i, in_ready, busy, ctrl, model_ctrl(ops[i], fs[i]));
                end
                @(negedge clk);
                cyc++;
            end
            tests_run++;
            if (cyc !== lat[i]) begin
                tests_failed++;
                $display("FAIL shift_latency[%0d]: got %0d cycles, want %0d", i, cyc, lat[i]);
            end
            tests_run++;
            e = sb.pop_front();
            if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z}) begin
                tests_failed++;
                $display("FAIL shift_result[%0d]: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                         i, out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        drive(2'b00, 4'd4, 8'hAA, 8'hFF);
        out_ready = 1'b0;
        @(negedge clk);
        drive(2'b01, 4'd0, 8'h01, 8'h02);
        for (int k = 0; k < 5; k++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || result !== 8'h55 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got ov=%b res=%h rdy=%b, want 1 55 0", k, out_valid, result, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got in_ready=%b, want 1", in_ready);
        end
        tests_run++;
        e = sb.pop_front();
        if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z}) begin
            tests_failed++;
            $display("FAIL bp_xor: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                     out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        e = sb.pop_front();
        if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z}) begin
            tests_failed++;
            $display("FAIL bp_next: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                     out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_idle: got ov=%b, want 0", out_valid);
        end
    endtask

    task automatic sweep_drive(input int i);
        logic [5:0] idx;
        if (i < 64) begin
            idx = 6'(i);
            drive(idx[5:4], idx[3:0], 8'($urandom), 8'($urandom) & 8'hF8);
        end else begin
            drive(2'b00, 4'd5, (i == 64) ? 8'hFF : 8'hFE, 8'($urandom));
        end
    endtask

    task automatic test_decode_sweep();
        out_ready = 1'b1;
        sweep_drive(0);
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            tests_run++;
            e = sb.pop_front();
            if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z}) begin
                tests_failed++;
                $display("FAIL decode[%0d]: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                         i, out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
            end
            if (i < 65) sweep_drive(i + 1);
            else in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b00;
        funct     = 4'd7;
        a         = 8'h80;
        b         = 8'h07;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, result, ctrl, busy, in_ready} !== {1'b0, 8'h00, 4'b0100, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL midshift_reset: got ov=%b res=%h ctrl=%b busy=%b rdy=%b, want 0 00 0100 0 1",
                     out_valid, result, ctrl, busy, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL midshift_lost: got out_valid/busy asserted after reset, want none");
        end
        drive(2'b01, 4'd0, 8'h05, 8'h06);
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        e = sb.pop_front();
        if ({out_valid, result, ctrl, zero} !== {1'b1, e.res, e.ctl, e.z}) begin
            tests_failed++;
            $display("FAIL midshift_recover: got ov=%b res=%h ctrl=%b z=%b, want ov=1 res=%h ctrl=%b z=%b",
                     out_valid, result, ctrl, zero, e.res, e.ctl, e.z);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shift();
        test_backpressure();
        test_decode_sweep();
        test_reset_mid_shift();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
